// File: rtl/ava_pkg.sv
// ava_pkg -- shared constants and types for the AVA VRAM arbiter.
//   URGENT_LEVEL : display FIFO occupancy below which display fetches win outright
//   CPU_MAX_WAIT : cycles a CPU request may be held off before it is forced through
//   CPU_WAIT_W   : width of the CPU wait counter
//   tag_t        : owner of the VRAM read that is currently in flight
//   ptr_t        : round-robin pointer, names the most recently granted requester
package ava_pkg;

   localparam int URGENT_LEVEL = 8;
   localparam int CPU_MAX_WAIT = 7;
   localparam int CPU_WAIT_W   = $clog2(CPU_MAX_WAIT + 1);

   typedef enum logic [1:0] {
      NONE   = 2'd0,
      DISP   = 2'd1,
      CPU_RD = 2'd2,
      CPU_WR = 2'd3
   } tag_t;

   typedef enum logic {
      LAST_DISP = 1'b0,
      LAST_CPU  = 1'b1
   } ptr_t;

endpackage

// File: rtl/ava_vram_arbiter.sv
// ava_vram_arbiter -- shares one single-port synchronous VRAM between the
// display fetch engine and the CPU.
//   clk, reset                 : clock, synchronous active-high reset
//   disp_req_*                 : display fetch request (valid/addr/ready)
//   disp_rdata_valid/disp_rdata: display read return, one cycle after grant
//   fifo_level                 : display FIFO occupancy, drives urgency
//   cpu_req_*                  : CPU request (valid/we/addr/wdata/be/ready)
//   cpu_rsp_valid/cpu_rsp_rdata: CPU response, one cycle after grant
//   vram_*                     : VRAM port, 1-cycle read latency
// Grant is combinational; priority is urgent display, then starved CPU, then
// round-robin, then the sole requester.
module ava_vram_arbiter
   import ava_pkg::*;
#(
   parameter int VRAM_ADDR_W = 16,
   parameter int FIFO_LVL_W  = 6
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   disp_req_valid,
   input  logic [VRAM_ADDR_W-1:0] disp_req_addr,
   output logic                   disp_req_ready,
   output logic                   disp_rdata_valid,
   output logic [31:0]            disp_rdata,
   input  logic [FIFO_LVL_W-1:0]  fifo_level,
   input  logic                   cpu_req_valid,
   input  logic                   cpu_req_we,
   input  logic [VRAM_ADDR_W-1:0] cpu_req_addr,
   input  logic [31:0]            cpu_req_wdata,
   input  logic [3:0]             cpu_req_be,
   output logic                   cpu_req_ready,
   output logic                   cpu_rsp_valid,
   output logic [31:0]            cpu_rsp_rdata,
   output logic                   vram_en,
   output logic [3:0]             vram_we,
   output logic [VRAM_ADDR_W-1:0] vram_addr,
   output logic [31:0]            vram_wdata,
   input  logic [31:0]            vram_rdata
);

   logic [CPU_WAIT_W-1:0] cpu_wait_cnt;
   ptr_t                  last_ptr;
   tag_t                  tag;

   logic disp_urgent;
   logic cpu_starved;
   logic grant_disp;
   logic grant_cpu;

   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path through the if/else chain can leave it unassigned and infer a latch.
   always_comb begin
      grant_disp  = 1'b0;
      grant_cpu   = 1'b0;
      disp_urgent = disp_req_valid && (fifo_level < FIFO_LVL_W'(URGENT_LEVEL));
      cpu_starved = cpu_req_valid && (cpu_wait_cnt == CPU_WAIT_W'(CPU_MAX_WAIT));
      // No grants while in reset, so nothing is issued that would need a response.
      if (!reset) begin
         if (disp_urgent) begin
            grant_disp = 1'b1;
         end else if (cpu_starved) begin
            grant_cpu = 1'b1;
         end else if (disp_req_valid && cpu_req_valid) begin
            if (last_ptr == LAST_CPU) grant_disp = 1'b1;
            else                      grant_cpu  = 1'b1;
         end else if (disp_req_valid) begin
            grant_disp = 1'b1;
         end else if (cpu_req_valid) begin
            grant_cpu = 1'b1;
         end
      end
   end

   always_comb begin
      disp_req_ready = grant_disp;
      cpu_req_ready  = grant_cpu;
      vram_en        = grant_disp || grant_cpu;
      vram_addr      = '0;
      vram_wdata     = '0;
      vram_we        = 4'b0000;
      if (grant_disp) begin
         vram_addr = disp_req_addr;
      end else if (grant_cpu) begin
         vram_addr  = cpu_req_addr;
         vram_wdata = cpu_req_wdata;
         if (cpu_req_we) vram_we = cpu_req_be;
      end
   end

   // Responses come straight from the tag and the VRAM read port; masking with
   // reset drops the return of a grant issued just before reset went high.
   always_comb begin
      disp_rdata_valid = !reset && (tag == DISP);
      cpu_rsp_valid    = !reset && ((tag == CPU_RD) || (tag == CPU_WR));
      disp_rdata       = disp_rdata_valid ? vram_rdata : 32'h0;
      cpu_rsp_rdata    = (!reset && (tag == CPU_RD)) ? vram_rdata : 32'h0;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         tag          <= NONE;
         last_ptr     <= LAST_CPU;
         cpu_wait_cnt <= '0;
      end else begin
         if (grant_disp)     tag <= DISP;
         else if (grant_cpu) tag <= cpu_req_we ? CPU_WR : CPU_RD;
         else                tag <= NONE;

         if (grant_disp)     last_ptr <= LAST_DISP;
         else if (grant_cpu) last_ptr <= LAST_CPU;

         if (!cpu_req_valid || grant_cpu)
            cpu_wait_cnt <= '0;
         else if (cpu_wait_cnt != CPU_WAIT_W'(CPU_MAX_WAIT))
            cpu_wait_cnt <= cpu_wait_cnt + 1'b1;
      end
   end

endmodule

// File: doc/ava_vram_arbiter.md
AVA_VRAM_ARBITER -- requirements
Module: ava_vram_arbiter

Interface
REQ-001 SHALL have parameter VRAM_ADDR_W, default 16, VRAM word-address width.
REQ-002 SHALL have parameter FIFO_LVL_W, default 6, display FIFO level width.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports disp_req_valid input 1, disp_req_addr input VRAM_ADDR_W, disp_req_ready output 1  display fetch request channel.
REQ-006 SHALL have ports disp_rdata_valid output 1, disp_rdata output 32  display read return.
REQ-007 SHALL have port fifo_level  input  FIFO_LVL_W  current display FIFO occupancy.
REQ-008 SHALL have ports cpu_req_valid input 1, cpu_req_we input 1, cpu_req_addr input VRAM_ADDR_W, cpu_req_wdata input 32, cpu_req_be input 4, cpu_req_ready output 1  CPU request channel.
REQ-009 SHALL have ports cpu_rsp_valid output 1, cpu_rsp_rdata output 32  CPU response.
REQ-010 SHALL have ports vram_en output 1, vram_we output 4, vram_addr output VRAM_ADDR_W, vram_wdata output 32, vram_rdata input 32  single-port synchronous VRAM, 1-cycle read latency.

Function
REQ-011 SHALL grant at most one requester per cycle; grant is combinational from valids, urgency, wait counter and registered priority pointer; granted channel's ready is high that cycle; transfer = valid && ready.
REQ-012 SHALL resolve priority: (1) display if disp_req_valid and fifo_level < URGENT_LEVEL; (2) CPU if cpu_req_valid and cpu_wait_cnt == CPU_MAX_WAIT; (3) round-robin: requester not granted most recently; (4) sole requester wins.
REQ-013 SHALL update the round-robin pointer (LAST_DISP / LAST_CPU) only on a grant, to the granted requester.
REQ-014 SHALL keep cpu_wait_cnt: +1 each cycle cpu_req_valid && !cpu_req_ready, saturating at CPU_MAX_WAIT; cleared on CPU grant or when cpu_req_valid is low.
REQ-015 SHALL drive vram_en = any grant; vram_addr/vram_wdata from granted channel; vram_we = cpu_req_be on CPU write grant, else 4'b0000.
REQ-016 SHALL drive vram_addr = 0, vram_wdata = 0, vram_we = 0 when no grant.
REQ-017 SHALL assert disp_rdata_valid exactly one cycle after a display grant, disp_rdata = vram_rdata that cycle.
REQ-018 SHALL assert cpu_rsp_valid exactly one cycle after any CPU grant; cpu_rsp_rdata = vram_rdata for reads, 32'h0 for writes.
REQ-019 SHALL track the in-flight owner in a registered tag (NONE/DISP/CPU_RD/CPU_WR); responses have no backpressure.
REQ-020 SHALL support a grant every cycle (back-to-back, alternating or same requester).
REQ-021 SHALL, with both urgent display and saturated CPU counter, grant display (urgency dominates).
REQ-022 SHALL hold disp_rdata and cpu_rsp_rdata at 0 when corresponding valid is low.

Reset
REQ-023 SHALL on reset: all ready/valid/en outputs 0, data/addr outputs 0, vram_we 0, pointer LAST_CPU (display wins first tie), cpu_wait_cnt 0, tag NONE.
REQ-024 SHALL suppress any response for a grant made in the cycle reset is asserted or earlier.

Structure
REQ-025 SHALL place URGENT_LEVEL (default 8), CPU_MAX_WAIT (default 7), and the tag/pointer enum typedefs in ava_pkg.
REQ-026 SHALL be a single module with no sub-modules.

Verification
REQ-027 Only disp valid, addr 0x0010, fifo_level 20 -> disp_req_ready=1 same cycle, vram_en=1, vram_addr=0x0010; next cycle disp_rdata_valid=1, disp_rdata=vram_rdata.
REQ-028 Both valid continuously, fifo_level 20, after reset -> grants alternate D,C,D,C; cpu_wait_cnt never exceeds 1.
REQ-029 CPU write addr 0x1234, wdata 0xDEADBEEF, be 4'b0011 alone -> vram_we=4'b0011 same cycle; next cycle cpu_rsp_valid=1, cpu_rsp_rdata=0.
REQ-030 Disp valid with fifo_level 3 for 10 cycles, CPU valid throughout -> display granted all 10 cycles, cpu_wait_cnt saturates at 7; fifo_level to 20 -> CPU granted next cycle.
REQ-031 CPU read granted, reset asserted next cycle -> cpu_rsp_valid stays 0; all outputs 0 following cycle.
REQ-032 No requests for 5 cycles -> vram_en=0, vram_addr=0, both readies 0, pointer unchanged.
